direction_queue: RTL and testbench

- Parametrised successor to the keypad direction decoder.
- Converts keypad scan codes into a 2-bit movement direction and buffers direction requests in a small FIFO.
- Edge-detects keyReady and rejects redundant and reversing requests.
- Releases exactly one buffered direction per game-step tick, so quick key combos (e.g. UP then LEFT within one step) are not lost. Sits between the keypad scanner and the game-step/movement logic.

---
 rtl/direction_queue.sv | 91 +++++++++
 tb/tb_direction_queue.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/direction_queue.sv
// Keypad scan-code to direction decoder with a small request FIFO.
// One buffered direction is released per game-step tick; redundant and reversing requests are filtered.
module direction_queue #(
    parameter int         KEY_W         = 5,
    parameter int         DEPTH         = 4,
    parameter logic [4:0] CODE_UP       = 5'h09,
    parameter logic [4:0] CODE_DOWN     = 5'h11,
    parameter logic [4:0] CODE_LEFT     = 5'h0c,
    parameter logic [4:0] CODE_RIGHT    = 5'h0e,
    parameter logic [1:0] INIT_DIR      = 2'b00,
    parameter bit         ALLOW_REVERSE = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [KEY_W-1:0]           keyCode,
    input  logic                       keyReady,
    input  logic                       tick,
    input  logic                       overflow_clr,
    output logic [1:0]                 direction,
    output logic                       dir_changed,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [1:0]    fifo [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, last_idx;
    logic          prev_ready, armed;
    logic          key_event, cand_vld, full, pop, push, accept, ovf_set, is_rev;
    logic [1:0]    cand, ref_dir;

    // armed stays low for the first clock after reset so a key held through reset is not an event
    assign key_event = keyReady & ~prev_ready & armed;

    always_comb begin
        cand_vld = 1'b1;
        cand     = 2'b00;
        if (keyCode == KEY_W'(CODE_UP))         cand = 2'b00;
        else if (keyCode == KEY_W'(CODE_DOWN))  cand = 2'b01;
        else if (keyCode == KEY_W'(CODE_RIGHT)) cand = 2'b10;
        else if (keyCode == KEY_W'(CODE_LEFT))  cand = 2'b11;
        else                                    cand_vld = 1'b0;
    end

    assign last_idx = wr_ptr - 1'b1;
    assign ref_dir  = (pending != '0) ? fifo[last_idx] : direction;
    assign is_rev   = (cand[1] == ref_dir[1]) && (cand[0] != ref_dir[0]);
    assign accept   = key_event && cand_vld && (cand != ref_dir) && (ALLOW_REVERSE || !is_rev);
    assign full     = (pending == FULL_CNT);
    assign pop      = tick && (pending != '0);
    assign push     = accept && (!full || pop);
    assign ovf_set  = accept && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_ready  <= 1'b0;
            armed       <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            pending     <= '0;
            direction   <= INIT_DIR;
            dir_changed <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            prev_ready  <= keyReady;
            armed       <= 1'b1;
            dir_changed <= 1'b0;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                direction   <= fifo[rd_ptr];
                dir_changed <= (fifo[rd_ptr] != direction);
            end
            case ({push, pop})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: pending <= pending;
            endcase
            // a new drop outranks a clear arriving in the same cycle
            if (ovf_set)           overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= cand;
    end

endmodule

// File: tb/tb_direction_queue.sv
// Directed bench for direction_queue: filtering, FIFO release per tick, overflow and reset behaviour.
module tb_direction_queue;
    localparam logic [4:0] K_UP = 5'h09, K_DN = 5'h11, K_LF = 5'h0c, K_RT = 5'h0e;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] keyCode = 5'h00;
    logic       keyReady = 1'b0;
    logic       tick = 1'b0;
    logic       overflow_clr = 1'b0;
    logic [1:0] direction, direction_r;
    logic       dir_changed, dir_changed_r, overflow, overflow_r;
    logic [2:0] pending, pending_r;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    direction_queue dut (
        .clk(clk), .rst(rst), .keyCode(keyCode), .keyReady(keyReady), .tick(tick),
        .overflow_clr(overflow_clr), .direction(direction), .dir_changed(dir_changed),
        .pending(pending), .overflow(overflow)
    );

    direction_queue #(.ALLOW_REVERSE(1'b1)) dut_rev (
        .clk(clk), .rst(rst), .keyCode(keyCode), .keyReady(keyReady), .tick(tick),
        .overflow_clr(overflow_clr), .direction(direction_r), .dir_changed(dir_changed_r),
        .pending(pending_r), .overflow(overflow_r)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] code);
        keyCode = code; keyReady = 1'b1; step(1);
        keyReady = 1'b0; step(1);
    endtask

    task automatic do_tick();
        tick = 1'b1; step(1); tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; step(1); rst = 1'b0; step(1);
    endtask

    initial begin
        #1;
        chk("rst_dir", 8'(direction), 8'h0);
        chk("rst_pending", 8'(pending), 8'h0);
        chk("rst_overflow", 8'(overflow), 8'h0);
        chk("rst_changed", 8'(dir_changed), 8'h0);
        step(1); rst = 1'b0; step(1);

        // idle ticks
        for (int i = 0; i < 3; i++) begin
            do_tick();
            chk("idle_changed", 8'(dir_changed), 8'h0);
        end
        chk("idle_dir", 8'(direction), 8'h0);
        chk("idle_pending", 8'(pending), 8'h0);

        // LEFT then DOWN, released one per tick
        press(K_LF);
        chk("combo_pend1", 8'(pending), 8'h1);
        press(K_DN);
        chk("combo_pend2", 8'(pending), 8'h2);
        do_tick();
        chk("combo_dir1", 8'(direction), 8'h3);
        chk("combo_chg1", 8'(dir_changed), 8'h1);
        chk("combo_pend3", 8'(pending), 8'h1);
        step(1);
        chk("combo_chg_low", 8'(dir_changed), 8'h0);
        do_tick();
        chk("combo_dir2", 8'(direction), 8'h1);
        chk("combo_chg2", 8'(dir_changed), 8'h1);
        chk("combo_pend4", 8'(pending), 8'h0);

        // reversal and redundancy filtering
        do_reset();
        press(K_DN);
        chk("rev_drop", 8'(pending), 8'h0);
        chk("rev_allow", 8'(pending_r), 8'h1);
        press(K_UP);
        chk("same_drop", 8'(pending), 8'h0);
        chk("rev_allow_up", 8'(pending_r), 8'h2);
        press(K_RT);
        chk("right_acc", 8'(pending), 8'h1);
        chk("right_acc_r", 8'(pending_r), 8'h3);

        // held key and invalid code
        do_reset();
        keyCode = K_LF; keyReady = 1'b1; step(20);
        keyReady = 1'b0; step(1);
        chk("hold_pend", 8'(pending), 8'h1);
        press(5'h03);
        chk("bad_pend", 8'(pending), 8'h1);
        chk("bad_dir", 8'(direction), 8'h0);

        // fill FIFO and overflow
        do_reset();
        press(K_LF); press(K_DN); press(K_RT); press(K_UP);
        chk("fill_pend", 8'(pending), 8'h4);
        chk("fill_ovf", 8'(overflow), 8'h0);
        press(K_LF);
        chk("ovf_pend", 8'(pending), 8'h4);
        chk("ovf_set", 8'(overflow), 8'h1);
        overflow_clr = 1'b1; step(1); overflow_clr = 1'b0;
        chk("ovf_clr", 8'(overflow), 8'h0);
        keyCode = K_RT; keyReady = 1'b1; tick = 1'b1; step(1);
        keyReady = 1'b0; tick = 1'b0;
        chk("pushpop_pend", 8'(pending), 8'h4);
        chk("pushpop_ovf", 8'(overflow), 8'h0);
        chk("pushpop_dir", 8'(direction), 8'h3);
        chk("pushpop_chg", 8'(dir_changed), 8'h1);
        step(1);
        keyCode = K_UP; keyReady = 1'b1; overflow_clr = 1'b1; step(1);
        keyReady = 1'b0; overflow_clr = 1'b0;
        chk("set_wins", 8'(overflow), 8'h1);
        step(1);
        do_tick();
        chk("drain_dir", 8'(direction), 8'h1);
        chk("drain_pend", 8'(pending), 8'h3);

        // asynchronous reset mid-stream with key held
        keyCode = K_LF; keyReady = 1'b1; rst = 1'b1; #1;
        chk("arst_dir", 8'(direction), 8'h0);
        chk("arst_pend", 8'(pending), 8'h0);
        chk("arst_ovf", 8'(overflow), 8'h0);
        chk("arst_chg", 8'(dir_changed), 8'h0);
        step(1); rst = 1'b0; step(4);
        chk("held_no_event", 8'(pending), 8'h0);
        keyReady = 1'b0; step(1);
        press(K_LF);
        chk("repress", 8'(pending), 8'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
